// File: rtl/gray_seq_ctrl_if.sv
// rtl/gray_seq_ctrl_if.sv - config/control/status bundle for the Gray sequence controller
//
// Purpose: groups the config handshake, run/abort controls and counter outputs.
// Ports (signals):
//   cfg_valid, cfg_start_gray[W], cfg_end_gray[W], cfg_wrap : config request
//   cfg_ready                                               : config accept (IDLE only)
//   run, abort                                              : advance enable / terminate
//   gray_out[W], bin_out[W], cnt_valid, done, busy          : counter status
// Modports: master drives config/control, slave is the controller.
interface gray_seq_ctrl_if #(
    parameter int W = 5
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_start_gray;
    logic [W-1:0] cfg_end_gray;
    logic         cfg_wrap;
    logic         run;
    logic         abort;
    logic [W-1:0] gray_out;
    logic [W-1:0] bin_out;
    logic         cnt_valid;
    logic         done;
    logic         busy;

    modport master (
        output cfg_valid, cfg_start_gray, cfg_end_gray, cfg_wrap, run, abort,
        input  cfg_ready, gray_out, bin_out, cnt_valid, done, busy
    );

    modport slave (
        input  cfg_valid, cfg_start_gray, cfg_end_gray, cfg_wrap, run, abort,
        output cfg_ready, gray_out, bin_out, cnt_valid, done, busy
    );
endinterface

// File: rtl/gray_seq_ctrl.sv
// rtl/gray_seq_ctrl.sv - sequencer stepping a Gray/binary counter over [start, end]
//
// Purpose: accepts Gray-coded range endpoints, counts in binary from start to
// end (modulo 2^W), presenting each value as Gray and binary with a strobe.
// One-shot or wrap-continuous, with run (stall) and abort control.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gray_seq_ctrl_if.slave (config handshake, run/abort, outputs)
module gray_seq_ctrl #(
    parameter int W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    gray_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] start_bin_q, start_bin_d;
    logic [W-1:0] end_bin_q, end_bin_d;
    logic         wrap_q, wrap_d;
    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;
    logic         cnt_valid_q, cnt_valid_d;
    logic         done_q, done_d;
    logic [W-1:0] bin_inc;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Natural W-bit overflow gives the modulo-2^W step through 2^W-1 -> 0.
    assign bin_inc = bin_q + {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        start_bin_d = start_bin_q;
        end_bin_d   = end_bin_q;
        wrap_d      = wrap_q;
        bin_d       = bin_q;
        gray_d      = gray_q;
        cnt_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    start_bin_d = g2b(bus.cfg_start_gray);
                    end_bin_d   = g2b(bus.cfg_end_gray);
                    wrap_d      = bus.cfg_wrap;
                    bin_d       = g2b(bus.cfg_start_gray);
                    gray_d      = bus.cfg_start_gray;
                    cnt_valid_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.run) begin
                    if (bin_q != end_bin_q) begin
                        bin_d       = bin_inc;
                        gray_d      = b2g(bin_inc);
                        cnt_valid_d = 1'b1;
                    end else if (!wrap_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Reload start; the pass boundary is flagged on the reload value.
                        bin_d       = start_bin_q;
                        gray_d      = b2g(start_bin_q);
                        cnt_valid_d = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_bin_q <= '0;
            end_bin_q   <= '0;
            wrap_q      <= 1'b0;
            bin_q       <= '0;
            gray_q      <= '0;
            cnt_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_bin_q <= start_bin_d;
            end_bin_q   <= end_bin_d;
            wrap_q      <= wrap_d;
            bin_q       <= bin_d;
            gray_q      <= gray_d;
            cnt_valid_q <= cnt_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.cfg_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.gray_out  = gray_q;
    assign bus.bin_out   = bin_q;
    assign bus.cnt_valid = cnt_valid_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb/tb_gray_seq_ctrl.sv - scoreboard bench for gray_seq_ctrl
module tb_gray_seq_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_seq_ctrl_if #(.W(W)) bus ();

    gray_seq_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] b;
        logic         cv;
        logic         d;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [W-1:0] g, input logic [W-1:0] b,
                        input logic cv, input logic d);
        exp_t e;
        e.g  = g;
        e.b  = b;
        e.cv = cv;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe (cnt_valid or done) consumes one expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            check("gray_invariant", {27'b0, bus.gray_out},
                  {27'b0, bus.bin_out ^ (bus.bin_out >> 1)});
            if (bus.cnt_valid || bus.done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual g=%b b=%0d cv=%b done=%b required no strobe",
                             bus.gray_out, bus.bin_out, bus.cnt_valid, bus.done);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_gray", {27'b0, bus.gray_out}, {27'b0, e.g});
                    check("sb_bin", {27'b0, bus.bin_out}, {27'b0, e.b});
                    check("sb_cnt_valid", {31'b0, bus.cnt_valid}, {31'b0, e.cv});
                    check("sb_done", {31'b0, bus.done}, {31'b0, e.d});
                end
            end
        end
    end

    task automatic do_cfg(input logic [W-1:0] sg, input logic [W-1:0] eg, input logic wrap);
        bus.cfg_start_gray = sg;
        bus.cfg_end_gray   = eg;
        bus.cfg_wrap       = wrap;
        bus.cfg_valid      = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit drained = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: actual %0d entries pending required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid      = 1'b0;
        bus.cfg_start_gray = '0;
        bus.cfg_end_gray   = '0;
        bus.cfg_wrap       = 1'b0;
        bus.run            = 1'b0;
        bus.abort          = 1'b0;

        // Reset state
        #12;
        check("rst_gray", {27'b0, bus.gray_out}, 32'd0);
        check("rst_bin", {27'b0, bus.bin_out}, 32'd0);
        check("rst_cnt_valid", {31'b0, bus.cnt_valid}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // 1: async reset mid-RUN at bin 7
        bus.run = 1'b0;
        push(5'b00100, 5'd7, 1'b1, 1'b0);
        do_cfg(5'b00100, 5'b01111, 1'b0);
        wait_drain();
        check("t1_busy_before", {31'b0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_gray", {27'b0, bus.gray_out}, 32'd0);
        check("t1_bin", {27'b0, bus.bin_out}, 32'd0);
        check("t1_cnt_valid", {31'b0, bus.cnt_valid}, 32'd0);
        check("t1_cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("t1_idle_ready", {31'b0, bus.cfg_ready}, 32'd1);
        check("t1_idle_busy", {31'b0, bus.busy}, 32'd0);

        // 2: one-shot 2..4
        bus.run = 1'b1;
        push(5'b00011, 5'd2, 1'b1, 1'b0);
        push(5'b00010, 5'd3, 1'b1, 1'b0);
        push(5'b00110, 5'd4, 1'b1, 1'b0);
        push(5'b00110, 5'd4, 1'b0, 1'b1);
        do_cfg(5'b00011, 5'b00110, 1'b0);
        wait_drain();
        @(negedge clk);
        #1;
        check("t2_cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);
        check("t2_done_low", {31'b0, bus.done}, 32'd0);
        check("t2_gray_hold", {27'b0, bus.gray_out}, 32'b00110);

        // 3: pass through 2^W-1 -> 0
        push(5'b10001, 5'd30, 1'b1, 1'b0);
        push(5'b10000, 5'd31, 1'b1, 1'b0);
        push(5'b00000, 5'd0, 1'b1, 1'b0);
        push(5'b00001, 5'd1, 1'b1, 1'b0);
        push(5'b00001, 5'd1, 1'b0, 1'b1);
        do_cfg(5'b10001, 5'b00001, 1'b0);
        wait_drain();
        @(negedge clk);
        #1;
        check("t3_cfg_ready", {31'b0, bus.cfg_ready}, 32'd1);

        // 4: continuous 0..2, done on each reload
        push(5'b00000, 5'd0, 1'b1, 1'b0);
        push(5'b00001, 5'd1, 1'b1, 1'b0);
        push(5'b00011, 5'd2, 1'b1, 1'b0);
        push(5'b00000, 5'd0, 1'b1, 1'b1);
        push(5'b00001, 5'd1, 1'b1, 1'b0);
        push(5'b00011, 5'd2, 1'b1, 1'b0);
        push(5'b00000, 5'd0, 1'b1, 1'b1);
        do_cfg(5'b00000, 5'b00011, 1'b1);
        wait_drain();
        check("t4_busy", {31'b0, bus.busy}, 32'd1);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("t4_abort_ready", {31'b0, bus.cfg_ready}, 32'd1);
        check("t4_abort_bin", {27'b0, bus.bin_out}, 32'd0);
        @(negedge clk);
        #1;
        check("t4_abort_done", {31'b0, bus.done}, 32'd0);

        // 5: stall at bin 3, then abort
        bus.run = 1'b0;
        push(5'b00010, 5'd3, 1'b1, 1'b0);
        do_cfg(5'b00010, 5'b01111, 1'b0);
        wait_drain();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t5_stall_bin", {27'b0, bus.bin_out}, 32'd3);
            check("t5_stall_cv", {31'b0, bus.cnt_valid}, 32'd0);
        end
        bus.abort = 1'b1;
        bus.run   = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("t5_abort_ready", {31'b0, bus.cfg_ready}, 32'd1);
        check("t5_abort_bin", {27'b0, bus.bin_out}, 32'd3);
        check("t5_abort_gray", {27'b0, bus.gray_out}, 32'b00010);
        check("t5_abort_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        #1;
        check("t5_idle_busy", {31'b0, bus.busy}, 32'd0);
        check("t5_idle_done", {31'b0, bus.done}, 32'd0);

        // 6a: config attempt while busy is ignored
        push(5'b00000, 5'd0, 1'b1, 1'b0);
        push(5'b00001, 5'd1, 1'b1, 1'b0);
        push(5'b00011, 5'd2, 1'b1, 1'b0);
        push(5'b00010, 5'd3, 1'b1, 1'b0);
        push(5'b00010, 5'd3, 1'b0, 1'b1);
        do_cfg(5'b00000, 5'b00010, 1'b0);
        bus.cfg_start_gray = 5'b11111;
        bus.cfg_end_gray   = 5'b10000;
        bus.cfg_wrap       = 1'b1;
        bus.cfg_valid      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check("t6_busy_ready", {31'b0, bus.cfg_ready}, 32'd0);
        end
        bus.cfg_valid = 1'b0;
        wait_drain();
        @(negedge clk);
        #1;

        // 6b: start == end single-value pass
        push(5'b00101, 5'd6, 1'b1, 1'b0);
        push(5'b00101, 5'd6, 1'b0, 1'b1);
        do_cfg(5'b00101, 5'b00101, 1'b0);
        wait_drain();
        @(negedge clk);
        #1;
        check("t6_single_ready", {31'b0, bus.cfg_ready}, 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
